demux_1to2: RTL and testbench

Stream demultiplexer, the inverse of the team's 2:1 mux. It routes a single valid/ready input stream to one of two output streams, selected by `in_sel`. Routing is packet-atomic: the select is latched on the first beat of a packet and held until the `in_last` beat. Each output has its own small FIFO, so a stalled consumer on one side never corrupts or reorders the other.

---
 rtl/demux_pkg.sv | 9 +
 rtl/demux_out_fifo.sv | 46 ++++
 rtl/demux_1to2.sv | 72 +++++++
 tb/tb_demux_1to2.sv | 129 ++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: shared types, route constants and sizing helper for the 1:2 stream demux.
package demux_pkg;
  typedef enum logic {IDLE, LOCK} state_t;
  localparam logic OUT0 = 1'b0;
  localparam logic OUT1 = 1'b1;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/demux_out_fifo.sv
// demux_out_fifo: per-output FIFO; full blocks push even when a pop happens the same cycle.
module demux_out_fifo
  import demux_pkg::*;
#(
  parameter int W     = 3,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         full,
  input  logic         pop,
  output logic         empty,
  output logic [W-1:0] head_data
);
  localparam int PW = ptr_w(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  logic push_ok, pop_ok;
  assign full      = cnt_q == (PW+1)'(DEPTH);
  assign empty     = cnt_q == '0;
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_data = mem_q[rd_q];
  always_comb begin
    wr_d  = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d  = pop_ok ? rd_q + 1'b1 : rd_q;
    cnt_d = (push_ok && !pop_ok) ? cnt_q + 1'b1 :
            (pop_ok && !push_ok) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push_ok) mem_q[wr_q] <= push_data;
    end
  end
endmodule

// File: rtl/demux_1to2.sv
// demux_1to2: packet-atomic 1:2 stream demux; select latched on first beat, held to last.
module demux_1to2
  import demux_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_last,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_last,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_last,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);
  state_t state_q, state_d;
  logic lock_sel_q, lock_sel_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic route, accept, full0, full1, empty0, empty1;
  logic [WIDTH:0] head0, head1;
  assign route    = (state_q == LOCK) ? lock_sel_q : in_sel;
  assign in_ready = (route == OUT1) ? !full1 : !full0;
  assign accept   = in_valid && in_ready;
  always_comb begin
    state_d    = accept ? (in_last ? IDLE : LOCK) : state_q;
    lock_sel_d = (accept && !in_last && state_q == IDLE) ? in_sel : lock_sel_q;
    cnt0_d     = (accept && in_last && route == OUT0) ? cnt0_q + 1'b1 : cnt0_q;
    cnt1_d     = (accept && in_last && route == OUT1) ? cnt1_q + 1'b1 : cnt1_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_sel_q <= OUT0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end
  demux_out_fifo #(.W(WIDTH + 1), .DEPTH(DEPTH)) u_fifo0 (
    .clk(clk), .rst_n(rst_n),
    .push(accept && route == OUT0), .push_data({in_data, in_last}), .full(full0),
    .pop(out0_ready), .empty(empty0), .head_data(head0)
  );
  demux_out_fifo #(.W(WIDTH + 1), .DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .rst_n(rst_n),
    .push(accept && route == OUT1), .push_data({in_data, in_last}), .full(full1),
    .pop(out1_ready), .empty(empty1), .head_data(head1)
  );
  assign out0_valid = !empty0;
  assign out1_valid = !empty1;
  assign {out0_data, out0_last} = head0;
  assign {out1_data, out1_last} = head1;
  assign busy     = state_q == LOCK;
  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;
endmodule

// File: tb/tb_demux_1to2.sv
// tb_demux_1to2: directed test-plan sequences plus random traffic against a queue-based model.
module tb_demux_1to2;
  localparam int W = 2, D = 2, CW = 8;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_sel = 0, in_last = 0, out0_ready = 0, out1_ready = 0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out0_valid, out1_valid, out0_last, out1_last, busy;
  logic [W-1:0] out0_data, out1_data;
  logic [CW-1:0] pkt_cnt0, pkt_cnt1;
  int n_chk = 0, n_pass = 0;
  logic [W:0] q0[$], q1[$];
  bit m_lock, m_sel;
  int m_c0, m_c1;
  always #5 clk = ~clk;
  demux_1to2 #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_last(in_last), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out0_data(out0_data), .out0_last(out0_last), .out1_valid(out1_valid),
    .out1_ready(out1_ready), .out1_data(out1_data), .out1_last(out1_last), .busy(busy),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic model_reset;
    q0.delete();
    q1.delete();
    m_lock = 0;
    m_sel = 0;
    m_c0 = 0;
    m_c1 = 0;
  endtask
  // Model: route and readiness come from packet state and queue occupancy only.
  task automatic step(input bit v, input logic [W-1:0] d, input bit s, input bit l,
                      input bit r0, input bit r1);
    bit r, rdy, acc, p0, p1;
    in_valid = v; in_data = d; in_sel = s; in_last = l; out0_ready = r0; out1_ready = r1;
    #1;
    r = m_lock ? m_sel : s;
    rdy = (r ? q1.size() : q0.size()) < D;
    acc = v && rdy;
    p0 = q0.size() != 0 && r0;
    p1 = q1.size() != 0 && r1;
    check("in_ready", in_ready, rdy);
    check("out0_valid", out0_valid, q0.size() != 0);
    check("out1_valid", out1_valid, q1.size() != 0);
    if (q0.size() != 0) check("out0_beat", {out0_data, out0_last}, q0[0]);
    if (q1.size() != 0) check("out1_beat", {out1_data, out1_last}, q1[0]);
    check("busy", busy, m_lock);
    check("pkt_cnt0", pkt_cnt0, m_c0);
    check("pkt_cnt1", pkt_cnt1, m_c1);
    @(posedge clk);
    if (p0) void'(q0.pop_front());
    if (p1) void'(q1.pop_front());
    if (acc) begin
      if (r) q1.push_back({d, l});
      else q0.push_back({d, l});
      if (l) begin
        if (r) m_c1 = (m_c1 + 1) % (1 << CW);
        else m_c0 = (m_c0 + 1) % (1 << CW);
        m_lock = 0;
      end else begin
        if (!m_lock) m_sel = s;
        m_lock = 1;
      end
    end
    @(negedge clk);
  endtask
  task automatic do_reset;
    #2 rst_n = 0;
    in_valid = 0;
    #1;
    check("rst_out0_valid", out0_valid, 0);
    check("rst_out1_valid", out1_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_pkt_cnt0", pkt_cnt0, 0);
    check("rst_pkt_cnt1", pkt_cnt1, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    model_reset();
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out0_valid", out0_valid, 0);
    check("rst_out1_valid", out1_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out0_data", {out0_data, out0_last}, 0);
    check("rst_out1_data", {out1_data, out1_last}, 0);
    check("rst_cnt", {pkt_cnt1, pkt_cnt0}, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    step(1, 2'b10, 0, 1, 1, 1);
    step(1, 2'b01, 1, 1, 1, 1);
    step(0, 2'b00, 0, 0, 1, 1);
    check("t1_pkt_cnt0", pkt_cnt0, 1);
    check("t1_pkt_cnt1", pkt_cnt1, 1);
    step(1, 2'b00, 1, 0, 1, 1);
    step(1, 2'b01, 0, 0, 1, 1);
    step(1, 2'b11, 0, 1, 1, 1);
    step(0, 2'b00, 0, 0, 1, 1);
    step(0, 2'b00, 0, 0, 1, 1);
    check("t2_pkt_cnt1", pkt_cnt1, 2);
    for (int i = 0; i < 4; i++) step(1, 2'(i), 0, 1, 0, 1);
    check("t3_in_ready_full", in_ready, 0);
    step(1, 2'b11, 1, 1, 0, 1);
    check("t4_out0_held", out0_valid, 1);
    for (int i = 0; i < 6; i++) step(i < 2, 2'(i + 2), 0, 1, 1, 1);
    step(1, 2'b01, 0, 0, 1, 1);
    step(1, 2'b10, 0, 0, 1, 1);
    do_reset();
    step(1, 2'b11, 1, 1, 1, 1);
    step(0, 2'b00, 0, 0, 1, 1);
    do_reset();
    for (int i = 0; i < 256; i++) step(1, 2'($urandom), 1, 1, 1'($urandom), 1);
    step(0, 2'b00, 0, 0, 1, 1);
    check("t6_pkt_cnt1_wrap", pkt_cnt1, 0);
    check("t6_pkt_cnt0", pkt_cnt0, 0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 7, 2'($urandom), 1'($urandom), $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
